// File: rtl/mem_march_master_if.sv
// Single-port synchronous memory bus between the march master and the memory it tests.
// The memory side updates mem_dout on the edge after a read (re=1, wr=0) and holds it otherwise.
interface mem_march_master_if #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH = 2
);
    logic                  mem_wr;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        output mem_wr,
        output mem_re,
        output mem_addr,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_wr,
        input  mem_re,
        input  mem_addr,
        input  mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_march_master.sv
// Built-in self-test driver: 3-pass march (write p, read p / write ~p, read ~p) over the
// whole memory, reporting pass/fail, a saturating error count and the first failing word.
module mem_march_master #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned MEM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    mem_march_master_if.master    mem,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH+1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StW0,
        StRw,
        StR1,
        StDrain,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [ADDR_WIDTH+1:0] err_cnt_q, err_cnt_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] first_addr_q, first_addr_d;
    logic [DATA_WIDTH-1:0] first_data_q, first_data_d;

    logic                  wr;
    logic                  re;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] din;
    logic                  chk_en;
    logic [DATA_WIDTH-1:0] chk_exp;
    logic [ADDR_WIDTH-1:0] chk_addr;

    // Pattern word for address a: seed xor a, with a resized to the data width.
    function automatic logic [DATA_WIDTH-1:0] pat(input logic [DATA_WIDTH-1:0] s,
                                                  input logic [ADDR_WIDTH-1:0] a);
        return s ^ DATA_WIDTH'(a);
    endfunction

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        phase_d      = phase_q;
        seed_d       = seed_q;
        err_cnt_d    = err_cnt_q;
        fail_d       = fail_q;
        first_addr_d = first_addr_q;
        first_data_d = first_data_q;
        wr           = 1'b0;
        re           = 1'b0;
        bus_addr     = '0;
        din          = '0;
        chk_en       = 1'b0;
        chk_exp      = '0;
        chk_addr     = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StW0;
                    addr_d       = '0;
                    phase_d      = 1'b0;
                    seed_d       = seed;
                    err_cnt_d    = '0;
                    fail_d       = 1'b0;
                    first_addr_d = '0;
                    first_data_d = '0;
                end
            end
            StW0: begin
                wr       = 1'b1;
                bus_addr = addr_q;
                din      = pat(seed_q, addr_q);
                if (addr_q == LastAddr) begin
                    addr_d  = '0;
                    state_d = StRw;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StRw: begin
                bus_addr = addr_q;
                if (!phase_q) begin
                    re      = 1'b1;
                    phase_d = 1'b1;
                end else begin
                    // Read data landed on the previous edge and stays put while wr=1.
                    wr       = 1'b1;
                    din      = ~pat(seed_q, addr_q);
                    chk_en   = 1'b1;
                    chk_exp  = pat(seed_q, addr_q);
                    chk_addr = addr_q;
                    phase_d  = 1'b0;
                    if (addr_q == LastAddr) begin
                        addr_d  = '0;
                        state_d = StR1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StR1: begin
                re       = 1'b1;
                bus_addr = addr_q;
                // Pipelined: this cycle's dout belongs to the previous address.
                if (addr_q != '0) begin
                    chk_en   = 1'b1;
                    chk_addr = addr_q - 1'b1;
                    chk_exp  = ~pat(seed_q, chk_addr);
                end
                if (addr_q == LastAddr) begin
                    addr_d  = '0;
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDrain: begin
                chk_en   = 1'b1;
                chk_addr = LastAddr;
                chk_exp  = ~pat(seed_q, LastAddr);
                state_d  = StDone;
            end
            default: state_d = StIdle;
        endcase

        if (chk_en && (mem.mem_dout != chk_exp)) begin
            fail_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (err_cnt_q == '0) begin
                first_addr_d = chk_addr;
                first_data_d = mem.mem_dout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            phase_q      <= 1'b0;
            seed_q       <= '0;
            err_cnt_q    <= '0;
            fail_q       <= 1'b0;
            first_addr_q <= '0;
            first_data_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            phase_q      <= phase_d;
            seed_q       <= seed_d;
            err_cnt_q    <= err_cnt_d;
            fail_q       <= fail_d;
            first_addr_q <= first_addr_d;
            first_data_q <= first_data_d;
        end
    end

    assign mem.mem_wr   = wr;
    assign mem.mem_re   = re;
    assign mem.mem_addr = bus_addr;
    assign mem.mem_din  = din;

    assign busy           = (state_q == StW0) || (state_q == StRw) ||
                            (state_q == StR1) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign fail           = fail_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_addr_q;
    assign first_err_data = first_data_q;

endmodule

// File: tb/tb_mem_march_master.sv
// Bench for mem_march_master: fault-injecting memory model, directed scenarios and randomized
// runs checked against a march-rule reference model.
module tb_mem_march_master;

    localparam int unsigned DW    = 2;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CMAX  = (1 << (AW + 2)) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, fail;
    logic [AW+1:0] err_cnt;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;

    mem_march_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

    mem_march_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .seed          (seed),
        .mem           (mif),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .err_cnt       (err_cnt),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;

    // Memory with per-word stuck-at-1 / stuck-at-0 masks applied on read.
    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] s1   [DEPTH];
    logic [DW-1:0] s0   [DEPTH];
    logic [DW-1:0] dout_q;
    assign mif.mem_dout = dout_q;

    always @(posedge clk) begin
        if (mif.mem_wr) mem[mif.mem_addr] <= mif.mem_din;
        else if (mif.mem_re) dout_q <= (mem[mif.mem_addr] | s1[mif.mem_addr]) & ~s0[mif.mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    assert property (@(posedge clk) !(mif.mem_wr && mif.mem_re))
        else $error("FAIL wr_re_excl: mem_wr and mem_re both high");

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t           wq[$];
    logic [AW-1:0] rq[$];

    always @(negedge clk) begin
        check_eq("wr_re_excl", 32'(mif.mem_wr & mif.mem_re), 0);
        if (!mif.mem_wr) check_eq("din_zero_idle", 32'(mif.mem_din), 0);
        if (!busy) check_eq("bus_quiet_idle", {30'd0, mif.mem_wr, mif.mem_re}, 0);
        if (mif.mem_wr) wq.push_back('{a: mif.mem_addr, d: mif.mem_din});
        if (mif.mem_re) rq.push_back(mif.mem_addr);
    end

    function automatic logic [DW-1:0] pat(input logic [DW-1:0] s, input int a);
        return s ^ DW'(a);
    endfunction

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            s1[a] = '0;
            s0[a] = '0;
            mem[a] = DW'($urandom);
        end
    endtask

    // Runs one full test; results checked against the march rules applied to the fault masks.
    task automatic run(input logic [DW-1:0] sd, input bit mid_start);
        int            cyc;
        int            ecnt;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [DW-1:0] want;
        logic [DW-1:0] seen;

        ecnt = 0;
        ea   = '0;
        ed   = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int a = 0; a < DEPTH; a++) begin
                want = (pass == 0) ? pat(sd, a) : ~pat(sd, a);
                seen = (want | s1[a]) & ~s0[a];
                if (seen != want) begin
                    if (ecnt == 0) begin
                        ea = AW'(a);
                        ed = seen;
                    end
                    ecnt++;
                end
            end
        end
        if (ecnt > CMAX) ecnt = CMAX;

        @(negedge clk);
        wq.delete();
        rq.delete();
        seed  = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed  = ~sd;
        check_eq("busy_after_start", 32'(busy), 1);
        check_eq("fail_cleared", 32'(fail), 0);
        check_eq("cnt_cleared", 32'(err_cnt), 0);
        check_eq("done_cleared", 32'(done), 0);

        cyc = 0;
        while (!done && cyc < 100) begin
            if (mid_start) start = (cyc == 2);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_eq("done_latency", 32'(cyc), 17);
        check_eq("busy_at_done", 32'(busy), 0);
        check_eq("fail_flag", 32'(fail), 32'(ecnt != 0));
        check_eq("err_cnt", 32'(err_cnt), 32'(ecnt));
        if (ecnt != 0) begin
            check_eq("first_err_addr", 32'(first_err_addr), 32'(ea));
            check_eq("first_err_data", 32'(first_err_data), 32'(ed));
        end

        check_eq("write_count", 32'(wq.size()), 2 * DEPTH);
        for (int i = 0; i < wq.size() && i < 2 * DEPTH; i++) begin
            check_eq("write_addr", 32'(wq[i].a), 32'(i % DEPTH));
            want = (i < DEPTH) ? pat(sd, i % DEPTH) : ~pat(sd, i % DEPTH);
            check_eq("write_data", 32'(wq[i].d), 32'(want));
        end
        check_eq("read_count", 32'(rq.size()), 2 * DEPTH);
        for (int i = 0; i < rq.size() && i < 2 * DEPTH; i++) begin
            check_eq("read_addr", 32'(rq[i]), 32'(i % DEPTH));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_faults();
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_fail", 32'(fail), 0);
        check_eq("rst_cnt", 32'(err_cnt), 0);
        check_eq("rst_bus", {30'd0, mif.mem_wr, mif.mem_re}, 0);
        #11 rst = 1'b0;

        // Clean memory, seed 01.
        run(2'b01, 1'b0);

        // Bit0 of address 2 stuck at 1.
        s1[2] = 2'b01;
        run(2'b01, 1'b0);
        check_eq("s2_cnt", 32'(err_cnt), 1);
        check_eq("s2_addr", 32'(first_err_addr), 2);
        check_eq("s2_data", 32'(first_err_data), 1);

        // Every word stuck at 0.
        clear_faults();
        for (int a = 0; a < DEPTH; a++) s0[a] = '1;
        run(2'b01, 1'b0);
        check_eq("s3_addr", 32'(first_err_addr), 0);
        check_eq("s3_data", 32'(first_err_data), 0);

        // From a failing DONE, restart clean with seed 10.
        clear_faults();
        run(2'b10, 1'b0);

        // Start pulse mid-W0 is ignored.
        run(2'b01, 1'b1);

        // Reset during RW.
        for (int a = 0; a < DEPTH; a++) s0[a] = '1;
        @(negedge clk);
        seed  = 2'b01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("pre_rst_fail", 32'(fail), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_bus", {30'd0, mif.mem_wr, mif.mem_re}, 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_done", 32'(done), 0);
        check_eq("mid_rst_fail", 32'(fail), 0);
        check_eq("mid_rst_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_faults();
        run(2'b01, 1'b0);

        // Randomized seeds and sparse stuck-at faults.
        for (int k = 0; k < 24; k++) begin
            clear_faults();
            for (int a = 0; a < DEPTH; a++) begin
                if ($urandom_range(0, 3) == 0) s1[a] = DW'($urandom);
                if ($urandom_range(0, 3) == 0) s0[a] = DW'($urandom);
            end
            run(DW'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
